fp8_to_fixed_pipelined: RTL

Converts FP8 operands (1 sign, 3 exponent, 4 mantissa, bias 3, implicit leading 1) into signed two's-complement fixed-point words.
It is a 3-stage pipeline with valid/ready handshakes on both sides and full backpressure.
It sits on the output side of fp8_mult_pipelined / fp8_add_pipelined, so FP8 MAC results can be consumed by integer datapaths and compared against fixed-point golden values.

---
 rtl/fp8_to_fixed_pipelined.sv | 108 ++++++++++
 1 files changed

// File: rtl/fp8_to_fixed_pipelined.sv
// FP8 (1/3/4, bias 3) to signed fixed-point converter: unpack, scale, sign/saturate.
// Three-stage valid/ready pipeline with full backpressure and collapsing bubbles.
module fp8_to_fixed_pipelined #(
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = 7
) (
    input  logic             clk96,
    input  logic             rst96,
    input  logic             in_valid96,
    output logic             in_ready96,
    input  logic [7:0]       in_fp896,
    output logic             out_valid96,
    input  logic             out_ready96,
    output logic [OUT_W-1:0] out_fixed96,
    output logic             out_sat96
);

    localparam int MAG_W = 20;
    localparam int SH_L  = (FRAC_BITS >= 7) ? FRAC_BITS - 7 : 0;
    localparam int SH_R  = (FRAC_BITS < 7) ? 7 - FRAC_BITS : 0;
    localparam logic [32:0]      MAX_EXT = (33'd1 << (OUT_W - 1)) - 33'd1;
    localparam logic [OUT_W-1:0] MAX_O   = MAX_EXT[OUT_W-1:0];

    // Stage registers
    logic             r_v1, r_s1, r_z1;
    logic [2:0]       r_e1;
    logic [4:0]       r_m1;
    logic             r_v2, r_s2;
    logic [MAG_W-1:0] r_mag2;
    logic             r_v3, r_sat3;
    logic [OUT_W-1:0] r_fixed3;

    logic             w_en1, w_en2, w_en3;
    logic [11:0]      w_mag7;
    logic [MAG_W-1:0] w_mag;
    logic             w_sat;
    logic [OUT_W-1:0] w_clamp, w_fixed;

    // A stage may load when it is empty or its successor is loading, so bubbles collapse.
    always_comb begin
        w_en3 = ~r_v3 | out_ready96;
        w_en2 = ~r_v2 | w_en3;
        w_en1 = ~r_v1 | w_en2;
    end

    assign in_ready96 = w_en1;

    // NOTE: always_comb gives every output a value on every path, so no latch is inferred.
    always_comb begin
        w_mag7 = 12'({7'd0, r_m1} << r_e1);
        w_mag  = '0;
        if (!r_z1) begin
            w_mag = (MAG_W'(w_mag7) << SH_L) >> SH_R;
        end
    end

    always_comb begin
        w_sat   = 33'(r_mag2) > MAX_EXT;
        w_clamp = w_sat ? MAX_O : OUT_W'(r_mag2);
        w_fixed = r_s2 ? -w_clamp : w_clamp;
    end

    // NOTE: state updates use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk96 or negedge rst96) begin
        if (!rst96) begin
            r_v1 <= 1'b0;
            r_s1 <= 1'b0;
            r_z1 <= 1'b0;
            r_e1 <= '0;
            r_m1 <= '0;
        end else if (w_en1) begin
            r_v1 <= in_valid96;
            r_s1 <= in_fp896[7];
            r_z1 <= (in_fp896[6:0] == 7'd0);
            r_e1 <= in_fp896[6:4];
            r_m1 <= {1'b1, in_fp896[3:0]};
        end
    end

    always_ff @(posedge clk96 or negedge rst96) begin
        if (!rst96) begin
            r_v2   <= 1'b0;
            r_s2   <= 1'b0;
            r_mag2 <= '0;
        end else if (w_en2) begin
            r_v2   <= r_v1;
            r_s2   <= r_s1;
            r_mag2 <= w_mag;
        end
    end

    always_ff @(posedge clk96 or negedge rst96) begin
        if (!rst96) begin
            r_v3     <= 1'b0;
            r_sat3   <= 1'b0;
            r_fixed3 <= '0;
        end else if (w_en3) begin
            r_v3     <= r_v2;
            r_sat3   <= w_sat;
            r_fixed3 <= w_fixed;
        end
    end

    assign out_valid96 = r_v3;
    assign out_fixed96 = r_fixed3;
    assign out_sat96   = r_sat3;

endmodule
